// File: rtl/operand_bank_if.sv
// Operand bank bus: switch/key inputs toward the bank, slot contents and status back out.
// The master side drives the front-end signals; the slave side is the bank itself.
interface operand_bank_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
);
    localparam int PW = $clog2(DEPTH);

    logic                   key;
    logic                   auto_mode;
    logic [PW-1:0]          sel;
    logic [WIDTH-1:0]       din;
    logic                   clear;
    logic [DEPTH*WIDTH-1:0] dout;
    logic [DEPTH-1:0]       valid;
    logic                   all_valid;
    logic [PW-1:0]          wr_ptr;
    logic                   load_pulse;
    logic                   reject;

    modport master (
        output key, auto_mode, sel, din, clear,
        input  dout, valid, all_valid, wr_ptr, load_pulse, reject
    );

    modport slave (
        input  key, auto_mode, sel, din, clear,
        output dout, valid, all_valid, wr_ptr, load_pulse, reject
    );
endinterface

// File: rtl/operand_bank.sv
// Operand storage for the calculator datapath: a debounced active-low key loads din into
// one of DEPTH slots, addressed by sel (manual) or by an auto-advancing write pointer.
module operand_bank #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 2,
    parameter int DEBOUNCE = 4
) (
    input  logic          clk,
    input  logic          reset,
    operand_bank_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEBOUNCE + 1);

    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE - 1);
    localparam logic [PW-1:0] PTR_LAST   = PW'(DEPTH - 1);
    localparam logic [PW:0]   SLOT_COUNT = (PW + 1)'(DEPTH);

    logic                   key_meta;
    logic                   key_sync;
    logic                   db;
    logic [CW-1:0]          cnt;
    logic                   press;

    logic                   do_load;
    logic                   do_reject;
    logic                   do_advance;
    logic [PW-1:0]          target;

    logic [DEPTH*WIDTH-1:0] data_q;
    logic [DEPTH-1:0]       valid_q;
    logic [PW-1:0]          wr_ptr_q;
    logic                   load_pulse_q;
    logic                   reject_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge
    // values; with blocking ones the two synchroniser stages would collapse into one.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_meta <= 1'b1;
            key_sync <= 1'b1;
        end else begin
            key_meta <= bus.key;
            key_sync <= key_meta;
        end
    end

    // The counter restarts whenever the synchronised level agrees with the accepted one,
    // so only an uninterrupted run of DEBOUNCE disagreeing samples flips db.
    always_ff @(posedge clk) begin
        if (reset) begin
            db  <= 1'b1;
            cnt <= '0;
        end else if (key_sync == db) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            db  <= key_sync;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // A press is the very edge at which db is about to fall.
    assign press = db && !key_sync && (cnt == CNT_LAST);

    // NOTE: every always_comb output gets a default before any branch, otherwise the
    // paths that do not assign it would infer a latch.
    always_comb begin
        do_load    = 1'b0;
        do_reject  = 1'b0;
        do_advance = 1'b0;
        target     = wr_ptr_q;
        if (press && !bus.clear) begin
            if (bus.auto_mode) begin
                if (&valid_q) begin
                    do_reject = 1'b1;
                end else begin
                    do_load    = 1'b1;
                    do_advance = 1'b1;
                end
            end else if ({1'b0, bus.sel} >= SLOT_COUNT) begin
                do_reject = 1'b1;
            end else begin
                do_load = 1'b1;
                target  = bus.sel;
            end
        end
    end

    // NOTE: the slot storage is reset rather than left uninitialised like a RAM, because
    // dout must read zero straight out of reset and after clear.
    always_ff @(posedge clk) begin
        if (reset || bus.clear) begin
            data_q   <= '0;
            valid_q  <= '0;
            wr_ptr_q <= '0;
        end else if (do_load) begin
            data_q[target*WIDTH +: WIDTH] <= bus.din;
            valid_q[target]               <= 1'b1;
            if (do_advance) begin
                wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            load_pulse_q <= 1'b0;
            reject_q     <= 1'b0;
        end else begin
            load_pulse_q <= do_load;
            reject_q     <= do_reject;
        end
    end

    assign bus.dout       = data_q;
    assign bus.valid      = valid_q;
    assign bus.all_valid  = &valid_q;
    assign bus.wr_ptr     = wr_ptr_q;
    assign bus.load_pulse = load_pulse_q;
    assign bus.reject     = reject_q;
endmodule

// File: tb/tb_operand_bank.sv
// Drives three operand banks (DEPTH 2, 3 and 4) with one shared key/switch stream and
// compares each against a slot-level reference model of the press rules.
module tb_operand_bank;
    localparam int W  = 8;
    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       key;
    logic       auto_mode;
    logic       clear;
    logic [1:0] sel;
    logic [7:0] din;

    always #5 clk = ~clk;

    operand_bank_if #(.WIDTH(W), .DEPTH(2)) b2 ();
    operand_bank_if #(.WIDTH(W), .DEPTH(3)) b3 ();
    operand_bank_if #(.WIDTH(W), .DEPTH(4)) b4 ();

    assign b2.key = key;  assign b2.auto_mode = auto_mode;  assign b2.clear = clear;
    assign b3.key = key;  assign b3.auto_mode = auto_mode;  assign b3.clear = clear;
    assign b4.key = key;  assign b4.auto_mode = auto_mode;  assign b4.clear = clear;
    assign b2.din = din;  assign b3.din = din;  assign b4.din = din;
    assign b2.sel = sel[0];
    assign b3.sel = sel;
    assign b4.sel = sel;

    operand_bank #(.WIDTH(W), .DEPTH(2), .DEBOUNCE(DB)) u_bank2 (.clk(clk), .reset(reset), .bus(b2));
    operand_bank #(.WIDTH(W), .DEPTH(3), .DEBOUNCE(DB)) u_bank3 (.clk(clk), .reset(reset), .bus(b3));
    operand_bank #(.WIDTH(W), .DEPTH(4), .DEBOUNCE(DB)) u_bank4 (.clk(clk), .reset(reset), .bus(b4));

    logic [31:0] o_dout  [3];
    logic [3:0]  o_valid [3];
    logic        o_all   [3];
    logic [1:0]  o_ptr   [3];
    logic        o_load  [3];
    logic        o_rej   [3];

    assign o_dout[0]  = 32'(b2.dout);   assign o_dout[1]  = 32'(b3.dout);   assign o_dout[2]  = 32'(b4.dout);
    assign o_valid[0] = 4'(b2.valid);   assign o_valid[1] = 4'(b3.valid);   assign o_valid[2] = 4'(b4.valid);
    assign o_all[0]   = b2.all_valid;   assign o_all[1]   = b3.all_valid;   assign o_all[2]   = b4.all_valid;
    assign o_ptr[0]   = 2'(b2.wr_ptr);  assign o_ptr[1]   = 2'(b3.wr_ptr);  assign o_ptr[2]   = 2'(b4.wr_ptr);
    assign o_load[0]  = b2.load_pulse;  assign o_load[1]  = b3.load_pulse;  assign o_load[2]  = b4.load_pulse;
    assign o_rej[0]   = b2.reject;      assign o_rej[1]   = b3.reject;      assign o_rej[2]   = b4.reject;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: plain slot arrays per bank.
    int         depth_of [3] = '{2, 3, 4};
    int         pw_of    [3] = '{1, 2, 2};
    logic [7:0] m_slot   [3][4];
    bit         m_valid  [3][4];
    int         m_ptr    [3];

    function automatic void m_clear(input int i);
        for (int k = 0; k < 4; k++) begin
            m_slot[i][k]  = 8'h00;
            m_valid[i][k] = 1'b0;
        end
        m_ptr[i] = 0;
    endfunction

    function automatic bit m_full(input int i);
        bit f = 1'b1;
        for (int k = 0; k < depth_of[i]; k++) f = f & m_valid[i][k];
        return f;
    endfunction

    function automatic void m_write(input int i, input int t, input logic [7:0] d);
        m_slot[i][t]  = d;
        m_valid[i][t] = 1'b1;
    endfunction

    function automatic void m_press(input int i, input bit a, input logic [1:0] s, input logic [7:0] d,
                                    input bit c, output bit el, output bit er);
        int t;
        el = 1'b0;
        er = 1'b0;
        t  = int'(s) % (1 << pw_of[i]);
        if (c) begin
            m_clear(i);
        end else if (a) begin
            if (m_full(i)) begin
                er = 1'b1;
            end else begin
                m_write(i, m_ptr[i], d);
                m_ptr[i] = (m_ptr[i] + 1) % depth_of[i];
                el = 1'b1;
            end
        end else if (t >= depth_of[i]) begin
            er = 1'b1;
        end else begin
            m_write(i, t, d);
            el = 1'b1;
        end
    endfunction

    function automatic logic [31:0] m_dout(input int i);
        logic [31:0] r = '0;
        for (int k = 0; k < depth_of[i]; k++) r = r | (32'(m_slot[i][k]) << (8 * k));
        return r;
    endfunction

    function automatic logic [31:0] m_valid_bits(input int i);
        logic [31:0] r = '0;
        for (int k = 0; k < depth_of[i]; k++) r = r | (32'(m_valid[i][k]) << k);
        return r;
    endfunction

    function automatic string nm(input string tag, input string what, input int i);
        return $sformatf("%s_%s_d%0d", tag, what, depth_of[i]);
    endfunction

    task automatic check_state(input string tag, input int i);
        check(nm(tag, "dout", i),      o_dout[i],  m_dout(i));
        check(nm(tag, "valid", i),     o_valid[i], m_valid_bits(i));
        check(nm(tag, "all_valid", i), o_all[i],   32'(m_full(i)));
        check(nm(tag, "wr_ptr", i),    o_ptr[i],   32'(m_ptr[i]));
    endtask

    int nl  [3];
    int nr  [3];
    int lat [3];

    // Samples #1 after each edge; k counts edges from the first one that sees key low.
    task automatic watch(input int low_len);
        for (int i = 0; i < 3; i++) begin
            nl[i]  = 0;
            nr[i]  = 0;
            lat[i] = -1;
        end
        for (int k = 1; k <= low_len + DB + 4; k++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                if ((o_load[i] || o_rej[i]) && lat[i] < 0) lat[i] = k;
                nl[i] += int'(o_load[i]);
                nr[i] += int'(o_rej[i]);
            end
            if (k == low_len) key = 1'b1;
        end
    endtask

    task automatic settle(input string tag, input bit pressed, input bit a, input logic [1:0] s,
                          input logic [7:0] d, input bit c);
        bit el;
        bit er;
        for (int i = 0; i < 3; i++) begin
            el = 1'b0;
            er = 1'b0;
            if (pressed) m_press(i, a, s, d, c, el, er);
            else if (c)  m_clear(i);
            check(nm(tag, "loads", i),   nl[i], 32'(el));
            check(nm(tag, "rejects", i), nr[i], 32'(er));
            if (el || er) check(nm(tag, "latency", i), lat[i], 32'(2 + DB));
            check_state(tag, i);
        end
    endtask

    task automatic press(input string tag, input bit a, input logic [1:0] s, input logic [7:0] d,
                         input bit c, input int low_len);
        @(negedge clk);
        auto_mode = a;
        sel       = s;
        din       = d;
        clear     = c;
        key       = 1'b0;
        watch(low_len);
        clear = 1'b0;
        settle(tag, low_len >= DB, a, s, d, c);
    endtask

    task automatic clear_only(input string tag);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_clear(i);
            check_state(tag, i);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        key       = 1'b1;
        auto_mode = 1'b0;
        clear     = 1'b0;
        sel       = 2'd0;
        din       = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_clear(i);
            check_state("reset", i);
            check(nm("reset", "load_pulse", i), o_load[i], 0);
            check(nm("reset", "reject", i),     o_rej[i],  0);
        end
        repeat (DB + 2) @(posedge clk);

        press("auto1", 1'b1, 2'd0, 8'h12, 1'b0, DB + 2);
        press("auto2", 1'b1, 2'd0, 8'h34, 1'b0, DB + 2);
        check("plan_auto_dout",  o_dout[0],  32'h3412);
        check("plan_auto_valid", o_valid[0], 32'h3);
        check("plan_auto_all",   o_all[0],   32'h1);
        check("plan_auto_ptr",   o_ptr[0],   32'h0);

        press("full", 1'b1, 2'd0, 8'h56, 1'b0, DB + 2);
        check("plan_full_dout", o_dout[0], 32'h3412);
        clear_only("clr1");
        press("after_clr", 1'b1, 2'd0, 8'h56, 1'b0, DB + 2);
        check("plan_after_clr_dout", o_dout[0], 32'h0056);

        press("glitch3", 1'b1, 2'd0, 8'h77, 1'b0, DB - 1);
        press("hold10",  1'b1, 2'd0, 8'h9A, 1'b0, 10);

        clear_only("clr2");
        press("man_sel2", 1'b0, 2'd2, 8'hAA, 1'b0, DB + 1);
        check("plan_man_valid", o_valid[1], 32'h4);
        check("plan_man_dout",  o_dout[1],  32'hAA0000);
        check("plan_man_ptr",   o_ptr[1],   32'h0);
        press("man_sel3", 1'b0, 2'd3, 8'hBB, 1'b0, DB + 1);

        press("clr_on_press", 1'b1, 2'd1, 8'h11, 1'b1, DB + 2);

        // Reset lands while the debounce count is 2, with key still held low.
        @(negedge clk);
        auto_mode = 1'b1;
        sel       = 2'd0;
        din       = 8'h66;
        key       = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_clear(i);
            check_state("rst_mid", i);
            check(nm("rst_mid", "load_pulse", i), o_load[i], 0);
            check(nm("rst_mid", "reject", i),     o_rej[i],  0);
        end
        watch(DB + 3);
        settle("rst_press", 1'b1, 1'b1, 2'd0, 8'h66, 1'b0);

        clear_only("clr3");
        for (int d = 1; d <= 4; d++) press($sformatf("wrap%0d", d), 1'b1, 2'd0, 8'(d), 1'b0, DB);
        check("plan_wrap_dout", o_dout[2], 32'h04030201);
        check("plan_wrap_ptr",  o_ptr[2],  32'h0);
        clear_only("clr4");
        press("wrap5", 1'b1, 2'd0, 8'h05, 1'b0, DB);
        check("plan_wrap5_dout", o_dout[2], 32'h5);
        check("plan_wrap5_ptr",  o_ptr[2],  32'h1);

        for (int n = 0; n < 30; n++) begin
            int op;
            op = int'($urandom_range(0, 9));
            if (op == 0) begin
                clear_only($sformatf("rnd%0d_clr", n));
            end else if (op == 1) begin
                press($sformatf("rnd%0d_glitch", n), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                      8'($urandom_range(0, 255)), 1'b0, int'($urandom_range(1, DB - 1)));
            end else begin
                press($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                      8'($urandom_range(0, 255)), ($urandom_range(0, 7) == 0), int'($urandom_range(DB, DB + 6)));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
